// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM states, oversampling and sample points.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  // Mid-bit sample points; the bit decision is taken at SAMPLE_HI.
  localparam logic [3:0] SAMPLE_LO  = 4'd7;
  localparam logic [3:0] SAMPLE_MID = 4'd8;
  localparam logic [3:0] SAMPLE_HI  = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  // Two-out-of-three vote over the mid-bit samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for the asynchronous rx line; resets to idle (high).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture; reset to 1 so a reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: x16 oversampled, 3-sample majority vote, LSB-first data,
// one stop bit. Pulses data_valid on a good frame, frame_err on a low stop bit.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);
  import uart_pkg::*;

  localparam logic [3:0] CNT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);

  logic                 w_rx_s;
  state_t               r_state,  w_state;
  logic [3:0]           r_cnt,    w_cnt;
  logic [3:0]           r_bit,    w_bit;
  logic [DATA_BITS-1:0] r_shift,  w_shift;
  logic                 r_s_lo,   w_s_lo;
  logic                 r_s_mid,  w_s_mid;
  logic [DATA_BITS-1:0] r_data,   w_data;
  logic                 r_valid,  w_valid;
  logic                 r_ferr,   w_ferr;
  logic                 w_maj;
  logic                 w_wrap;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rx),
    .o_q (w_rx_s)
  );

  // Vote uses the two stored samples plus the live count-9 sample.
  assign w_maj  = maj3(r_s_lo, r_s_mid, w_rx_s);
  assign w_wrap = (r_cnt == CNT_LAST);

  // Next-state and datapath decisions; nothing moves except on a tick.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_s_lo  = r_s_lo;
    w_s_mid = r_s_mid;
    w_data  = r_data;
    w_valid = 1'b0;
    w_ferr  = 1'b0;
    if (tick) begin
      if (r_state != IDLE && r_state != WAIT_IDLE) begin
        w_cnt = w_wrap ? 4'd0 : r_cnt + 4'd1;
        if (r_cnt == SAMPLE_LO)  w_s_lo  = w_rx_s;
        if (r_cnt == SAMPLE_MID) w_s_mid = w_rx_s;
      end
      case (r_state)
        IDLE: begin
          // The detecting tick is count 0, so the next tick is count 1.
          if (!w_rx_s) begin
            w_state = START;
            w_cnt   = 4'd1;
            w_bit   = 4'd0;
          end
        end
        START: begin
          if (r_cnt == SAMPLE_HI && w_maj) begin
            w_state = IDLE;
            w_cnt   = 4'd0;
          end else if (w_wrap) begin
            w_state = DATA;
            w_bit   = 4'd0;
          end
        end
        DATA: begin
          if (r_cnt == SAMPLE_HI) w_shift = {w_maj, r_shift[DATA_BITS-1:1]};
          if (w_wrap) begin
            if (r_bit == BIT_LAST) w_state = STOP;
            else                   w_bit   = r_bit + 4'd1;
          end
        end
        STOP: begin
          // Leave at mid-stop so a following start bit is caught without a gap.
          if (r_cnt == SAMPLE_HI) begin
            w_cnt = 4'd0;
            if (w_maj) begin
              w_data  = r_shift;
              w_valid = 1'b1;
              w_state = IDLE;
            end else begin
              w_ferr  = 1'b1;
              w_state = WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (w_rx_s) w_state = IDLE;
        end
        default: w_state = IDLE;
      endcase
    end
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_s_lo  <= 1'b1;
      r_s_mid <= 1'b1;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_s_lo  <= w_s_lo;
      r_s_mid <= w_s_mid;
      r_data  <= w_data;
      r_valid <= w_valid;
      r_ferr  <= w_ferr;
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign frame_err  = r_ferr;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus random frames (data, stop bit,
// single-tick glitches, idle gaps) checked against a frame-level model.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int n_vec;
  int n_err;
  int viol;

  // Frame outcomes: {7'b0, is_err, data}. Model pushes expected, monitor observed.
  logic [15:0] q_exp[$];
  logic [15:0] q_got[$];
  logic [7:0]  last_good;

  uart_rx #(.DATA_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-clk tick every 4 clks, changed on the falling edge.
  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  // Pulse monitor: records each output pulse and flags width/overlap errors.
  initial begin
    logic pv, pe;
    pv = 1'b0;
    pe = 1'b0;
    forever begin
      @(negedge clk);
      if (data_valid) q_got.push_back({8'h00, data_out});
      if (frame_err)  q_got.push_back(16'h0100);
      if ((data_valid && pv) || (frame_err && pe) || (data_valid && frame_err)) viol++;
      pv = data_valid;
      pe = frame_err;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns #1 after the n-th tick edge, so rx changes land between ticks.
  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      do @(posedge clk); while (tick !== 1'b1);
    end
    #1;
  endtask

  // Drives one frame aligned to tick boundaries; gbit<0 means no glitch,
  // otherwise bit gbit is inverted for the single tick at count gcnt.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int gbit, input int gcnt);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      if (i == gbit) begin
        rx = d[i];
        wait_ticks(gcnt);
        rx = ~d[i];
        wait_ticks(1);
        rx = d[i];
        wait_ticks(15 - gcnt);
      end else begin
        rx = d[i];
        wait_ticks(16);
      end
    end
    rx = stop;
    wait_ticks(16);
    if (stop) begin
      q_exp.push_back({8'h00, d});
      last_good = d;
    end else begin
      q_exp.push_back(16'h0100);
    end
  endtask

  task automatic checkpoint(input string tag);
    chk({tag, ".npulse"}, q_got.size(), q_exp.size());
    while (q_got.size() > 0 && q_exp.size() > 0)
      chk({tag, ".pulse"}, q_got.pop_front(), q_exp.pop_front());
    q_got.delete();
    q_exp.delete();
    chk({tag, ".data_out"}, data_out, last_good);
    chk({tag, ".pulse_shape"}, viol, 0);
    viol = 0;
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    int         gbit, gcnt, gap;

    n_vec = 0;
    n_err = 0;
    viol = 0;
    last_good = 8'h00;
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.data_out", data_out, 8'h00);
    chk("rst.data_valid", data_valid, 1'b0);
    chk("rst.frame_err", frame_err, 1'b0);
    chk("rst.busy", busy, 1'b0);
    rst = 1'b0;
    wait_ticks(4);

    // Clean 0xA5 frame.
    send_frame(8'hA5, 1'b1, -1, 0);
    chk("a5.busy", busy, 1'b0);
    checkpoint("a5");

    // 0x3C with a low stop bit: error pulse, data_out keeps 0xA5.
    send_frame(8'h3C, 1'b0, -1, 0);
    wait_ticks(10);
    chk("ferr.busy_held", busy, 1'b1);
    rx = 1'b1;
    wait_ticks(1);
    chk("ferr.busy_released", busy, 1'b0);
    checkpoint("ferr");
    wait_ticks(3);

    // False start: 4 ticks low, rejected at count 9.
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(4);
    chk("false.busy_mid", busy, 1'b1);
    wait_ticks(3);
    chk("false.busy_after", busy, 1'b0);
    checkpoint("false");
    send_frame(8'h3C, 1'b1, -1, 0);
    checkpoint("3c");

    // 0xFF with a one-tick low glitch at count 8 of bit 3.
    send_frame(8'hFF, 1'b1, 3, 8);
    checkpoint("glitch");

    // Back-to-back frames without idle time.
    send_frame(8'h55, 1'b1, -1, 0);
    send_frame(8'h0F, 1'b1, -1, 0);
    checkpoint("b2b");

    // Reset in the middle of data bit 4.
    d = 8'hC3;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = d[4];
    wait_ticks(5);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rstmid.data_out", data_out, 8'h00);
    chk("rstmid.data_valid", data_valid, 1'b0);
    chk("rstmid.frame_err", frame_err, 1'b0);
    chk("rstmid.busy", busy, 1'b0);
    last_good = 8'h00;
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ticks(20);
    checkpoint("rstmid");
    send_frame(8'h81, 1'b1, -1, 0);
    checkpoint("81");

    // Random frames.
    for (int n = 0; n < 40; n++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      gbit = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
      gcnt = int'($urandom_range(7, 9));
      send_frame(d, stop, gbit, gcnt);
      if (!stop) begin
        wait_ticks(int'($urandom_range(0, 6)));
        chk("rand.busy_wait", busy, 1'b1);
        rx = 1'b1;
        wait_ticks(int'($urandom_range(1, 5)));
      end else begin
        gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 20));
        wait_ticks(gap);
      end
      checkpoint("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame; legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16, ticks per bit period; fixed at 16 in this revision.
REQ-003 Port clk, input, 1, system clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, reset; asynchronous, active-high.
REQ-005 Port tick, input, 1, single-cycle x16 oversample strobe from the baud generator.
REQ-006 Port rx, input, 1, asynchronous serial line; idle high.
REQ-007 Port data_out, output, DATA_BITS, last correctly framed byte.
REQ-008 Port data_valid, output, 1, one-clk pulse when data_out is updated.
REQ-009 Port frame_err, output, 1, one-clk pulse when the stop bit samples low.
REQ-010 Port busy, output, 1, high whenever state is not IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; only the synchronized value (rx_s) is used.
REQ-012 All sampling, counting and state transitions SHALL occur only on clk edges where tick=1; on non-tick cycles, the 4-bit tick counter and the state SHALL hold.
REQ-013 Tick counter SHALL count 0..15 within each bit and wrap 15->0 at the bit boundary.
REQ-014 Bit value SHALL be the majority of rx_s at counts 7, 8 and 9; the decision is taken at count 9.
REQ-015 States: IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-016 IDLE: on a tick with rx_s=0 -> START, with that tick treated as count 0.
REQ-017 START: majority 1 at count 9 -> IDLE (false start, no output pulse); majority 0 -> continue; at count 15 -> DATA.
REQ-018 DATA: each bit's majority SHALL be shifted in LSB-first; after DATA_BITS bits, at count 15 -> STOP.
REQ-019 STOP, count 9, majority 1: data_out <= shift register, data_valid pulses, -> IDLE immediately, allowing back-to-back frames.
REQ-020 STOP, count 9, majority 0: frame_err pulses, data_out SHALL NOT change, -> WAIT_IDLE.
REQ-021 WAIT_IDLE: remain until a tick with rx_s=1, then -> IDLE.
REQ-022 data_valid and frame_err SHALL be registered, high for exactly one clk, starting the cycle after the count-9 stop tick; never both high.
REQ-023 data_out SHALL hold its value until the next valid frame; there is no consumer handshake, and a new frame overwrites data_out.
REQ-024 Latency: rx edge to rx_s is 2 clks; the start edge is recognized on the first tick after rx_s falls.

Reset
REQ-025 On rst: state=IDLE, counter=0, bit index=0, shift register=0, synchronizer flops=1, data_out=0, data_valid=0, frame_err=0, busy=0.
REQ-026 A reset asserted mid-frame SHALL abort the frame with no output pulse; after release, the next falling edge starts a fresh frame.

Structure
REQ-027 Shared package uart_pkg SHALL hold the state enumeration, OVERSAMPLE, and sample-point constants SAMPLE_LO=7, SAMPLE_MID=8, SAMPLE_HI=9.
REQ-028 The synchronizer SHALL be a separate sub-module sync_2ff with reset value 1; the remaining logic is a single FSM module.

Verification
REQ-029 Frame 0xA5 (bits 1,0,1,0,0,1,0,1), stop bit 1 -> data_out=0xA5, data_valid one clk, frame_err=0, busy then 0.
REQ-030 rx low for 4 ticks then high -> no pulses, busy falls after count 9, next 0x3C frame received correctly.
REQ-031 Data 0x3C with stop bit 0 -> frame_err one clk, data_out unchanged, busy held until rx returns high.
REQ-032 0xFF with rx glitched low for 1 tick at count 8 of bit 3 -> data_out=0xFF (majority rejects the glitch).
REQ-033 0x55 then 0x0F back-to-back, no idle gap -> two data_valid pulses, with values 0x55 then 0x0F.
REQ-034 rst pulsed during DATA bit 4 -> all outputs at reset values, no pulse; the following 0x81 frame is received correctly.
